// File: rtl/ysyx_22050598_ifu_pkg.sv
// Shared constants and FSM state encoding for the ysyx_22050598 instruction fetch unit.
package ysyx_22050598_ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 64;

  localparam logic [PC_W-1:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [PC_W-1:0] PC_STEP      = 64'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } ifu_state_e;

  // Fetches are word-aligned; the byte offset of a target is ignored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22050598_ifu_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} pairs; flush empties it in one cycle.
// Empty/full are registered from the next-cycle occupancy.
module ysyx_22050598_ifu_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             push_s;
  logic             pop_s;

  assign push_s      = push & ~full_r;
  assign pop_s       = pop & ~empty_r;
  assign count_nxt_s = flush ? {CW{1'b0}} : (count_r + CW'(push_s) - CW'(pop_s));

  // Storage, pointers and occupancy flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s && !flush) begin
        mem_r[wr_ptr_r] <= push_data;
      end
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {CW{1'b0}});
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/ysyx_22050598_ifu.sv
// Instruction fetch unit: PC, single-outstanding imem fetch FSM and decode-side buffer.
// Optional perf counters enabled by YSYX_22050598_IFU_PERF_CNT_EN.
module ysyx_22050598_ifu
  import ysyx_22050598_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = IFU_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
`ifdef YSYX_22050598_IFU_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e             state_r;
  logic [PC_W-1:0]        pc_r;
  logic                   req_valid_r;
  logic                   req_hs_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   room_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CW-1:0]          fifo_count_s;
  logic [CW-1:0]          occ_nxt_s;
  logic [PC_W+INST_W-1:0] head_s;

  assign req_hs_s = req_valid_r & imem_req_ready;
  assign pop_s    = ~fifo_empty_s & inst_ready;
  assign push_s   = (state_r == ST_WAIT) & imem_resp_valid & ~redirect_valid & ~fifo_full_s;

  // A request may be raised next cycle only if a slot will be free for its response.
  assign occ_nxt_s = redirect_valid ? {CW{1'b0}}
                                    : (fifo_count_s + CW'(push_s) - CW'(pop_s));
  assign room_s    = (occ_nxt_s < CW'(FIFO_DEPTH));

  // Fetch FSM, PC and registered request-valid; redirect outranks every other event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      req_valid_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r <= align_pc(redirect_pc);
      case (state_r)
        ST_IDLE: begin state_r <= ST_REQ; req_valid_r <= room_s; end
        ST_REQ: begin
          if (req_hs_s) begin state_r <= ST_DROP; req_valid_r <= 1'b0; end
          else begin state_r <= ST_REQ; req_valid_r <= room_s; end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin state_r <= ST_REQ; req_valid_r <= room_s; end
          else begin state_r <= ST_DROP; req_valid_r <= 1'b0; end
        end
        ST_DROP: begin state_r <= ST_DROP; req_valid_r <= 1'b0; end
        default: begin state_r <= ST_IDLE; req_valid_r <= 1'b0; end
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin state_r <= ST_REQ; req_valid_r <= room_s; end
        ST_REQ: begin
          if (req_hs_s) begin state_r <= ST_WAIT; req_valid_r <= 1'b0; end
          else begin state_r <= ST_REQ; req_valid_r <= room_s; end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state_r     <= ST_REQ;
            pc_r        <= pc_r + PC_STEP;
            req_valid_r <= room_s;
          end else begin
            state_r     <= ST_WAIT;
            req_valid_r <= 1'b0;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) begin state_r <= ST_REQ; req_valid_r <= room_s; end
          else begin state_r <= ST_DROP; req_valid_r <= 1'b0; end
        end
        default: begin state_r <= ST_IDLE; req_valid_r <= 1'b0; end
      endcase
    end
  end

  ysyx_22050598_ifu_fifo #(
    .WIDTH (PC_W + INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({pc_r, imem_resp_data}),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .head_data (head_s)
  );

`ifdef YSYX_22050598_IFU_PERF_CNT_EN
  // Delivered instructions and cycles where fetch is active but decode has nothing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else begin
      if (pop_s) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (fifo_empty_s && (state_r != ST_IDLE)) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = ~fifo_empty_s;
  assign inst           = head_s[INST_W-1:0];
  assign inst_pc        = head_s[PC_W+INST_W-1:INST_W];

endmodule

// File: tb/tb_ysyx_22050598_ifu.sv
// Self-checking bench for ysyx_22050598_ifu: memory model plus {pc, inst} scoreboard.
module tb_ysyx_22050598_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef YSYX_22050598_IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ysyx_22050598_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
`ifdef YSYX_22050598_IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int lat = 1;

  logic [95:0] exp_q[$];
  logic [63:0] acc_q[$];

  bit          pend = 1'b0;
  bit          pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = 64'd0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock cycle: memory response, scoreboard pop, request logging, then the edge.
  task automatic step();
    logic        resp_now;
    logic        hs;
    logic [63:0] hs_addr;
    logic [95:0] e;
    resp_now = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) resp_now = 1'b1;
      else pend_cnt = pend_cnt - 1;
    end
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    if (resp_now && !pend_stale && !redirect_valid && rst_n)
      exp_q.push_back({pend_addr, mem_word(pend_addr)});
    if (inst_valid && inst_ready && rst_n) begin
      total++;
      delivered++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL deliver_unexpected: got pc=%h inst=%h, required no delivery", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        if ({inst_pc, inst} !== e) begin
          bad++;
          $display("FAIL deliver: got pc=%h inst=%h, required pc=%h inst=%h",
                   inst_pc, inst, e[95:32], e[31:0]);
        end
      end
    end
    hs      = imem_req_valid && imem_req_ready && rst_n;
    hs_addr = imem_req_addr;
    if (hs) acc_q.push_back(hs_addr);
    if (redirect_valid || !rst_n) exp_q.delete();
    @(posedge clk);
    if (resp_now) pend = 1'b0;
    if (pend && (redirect_valid || !rst_n)) pend_stale = 1'b1;
    if (hs) begin
      pend       = 1'b1;
      pend_addr  = hs_addr;
      pend_cnt   = lat - 1;
      pend_stale = redirect_valid;
    end
    @(negedge clk);
  endtask

  task automatic wait_acc(input int max_cycles);
    int n0;
    n0 = acc_q.size();
    for (int i = 0; i < max_cycles && acc_q.size() == n0; i++) step();
  endtask

  task automatic wait_delivery(input int max_cycles);
    int d0;
    d0 = delivered;
    for (int i = 0; i < max_cycles && delivered == d0; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    step(); step();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
    total++; if (inst !== 32'd0) begin bad++; $display("FAIL rst_inst: got %h, required 0", inst); end
    total++; if (inst_pc !== 64'd0) begin bad++; $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
    total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL rst_pc: got %h, required %h", imem_req_addr, RST_PC); end
    rst_n = 1'b1;
    step();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      bad++; $display("FAIL first_req: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    int d0;
    logic [63:0] want;
    logic [63:0] got;
    acc_q.delete(); d0 = delivered; lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 40 && delivered - d0 < 3; i++) step();
    total++; if (delivered - d0 < 3) begin bad++; $display("FAIL seq_timeout: got %0d words, required 3", delivered - d0); end
    for (int k = 0; k < 3; k++) begin
      want = RST_PC + 64'(4 * k);
      got  = (acc_q.size() > k) ? acc_q[k] : 64'hx;
      total++; if (got !== want) begin bad++; $display("FAIL seq_addr%0d: got %h, required %h", k, got, want); end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0; imem_req_ready = 1'b1; lat = 1;
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 10) begin
        total++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== mem_word(RST_PC)) begin
          bad++;
          $display("FAIL bp_hold%0d: got req_valid=%b inst_valid=%b pc=%h inst=%h, required 0 1 %h %h",
                   i, imem_req_valid, inst_valid, inst_pc, inst, RST_PC, mem_word(RST_PC));
        end
      end
    end
    total++; if (exp_q.size() != 2) begin bad++; $display("FAIL bp_count: got %0d buffered, required 2", exp_q.size()); end
    total++; if (pend !== 1'b0) begin bad++; $display("FAIL bp_outstanding: got %b, required 0", pend); end
    inst_ready = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_redirect_wait();
    inst_ready = 1'b1; imem_req_ready = 1'b1; lat = 4;
    wait_acc(40);
    total++; if (!pend) begin bad++; $display("FAIL rw_no_req: got pend=%b, required 1", pend); end
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1003;
    step();
    redirect_valid = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_flush: got inst_valid=%b, required 0", inst_valid); end
    acc_q.delete();
    wait_acc(40);
    total++;
    if (acc_q.size() == 0 || acc_q[0] !== 64'h0000_0000_8000_1000) begin
      bad++; $display("FAIL rw_next_addr: got %h, required %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, 64'h0000_0000_8000_1000);
    end
    wait_delivery(40);
  endtask

  task automatic test_redirect_resp();
    lat = 2; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 40 && !(pend && !pend_stale && pend_cnt == 0); i++) step();
    total++; if (!(pend && pend_cnt == 0)) begin bad++; $display("FAIL rr_no_resp_due: got pend=%b, required 1", pend); end
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_3000;
    acc_q.delete();
    step();
    redirect_valid = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rr_flush: got inst_valid=%b, required 0", inst_valid); end
    wait_acc(40);
    total++;
    if (acc_q.size() == 0 || acc_q[0] !== 64'h0000_0000_8000_3000) begin
      bad++; $display("FAIL rr_next_addr: got %h, required %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, 64'h0000_0000_8000_3000);
    end
    wait_delivery(40);
  endtask

  task automatic test_redirect_req();
    int d0;
    lat = 1; imem_req_ready = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 40 && !(imem_req_valid && !pend); i++) step();
    for (int c = 0; c < 5; c++) begin
      redirect_valid = (c == 2);
      redirect_pc    = 64'h0000_0000_8000_2000;
      step();
      if (c >= 2) begin
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0000_0000_8000_2000) begin
          bad++; $display("FAIL rq_hold%0d: got valid=%b addr=%h, required 1 %h", c, imem_req_valid, imem_req_addr, 64'h0000_0000_8000_2000);
        end
      end
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    acc_q.delete(); d0 = delivered;
    wait_acc(10);
    total++;
    if (acc_q.size() == 0 || acc_q[0] !== 64'h0000_0000_8000_2000) begin
      bad++; $display("FAIL rq_accept: got %h, required %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, 64'h0000_0000_8000_2000);
    end
    wait_delivery(20);
    total++; if (delivered == d0) begin bad++; $display("FAIL rq_deliver: got 0 words, required 1"); end
  endtask

  task automatic test_reset_mid();
    int d0;
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    wait_acc(40);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    acc_q.delete(); d0 = delivered;
    wait_acc(20);
    total++;
    if (acc_q.size() == 0 || acc_q[0] !== RST_PC) begin
      bad++; $display("FAIL rm_first_req: got %h, required %h", (acc_q.size() > 0) ? acc_q[0] : 64'hx, RST_PC);
    end
    wait_delivery(20);
    total++; if (delivered == d0) begin bad++; $display("FAIL rm_deliver: got 0 words, required 1"); end
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0; inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_redirect_req();
    test_reset_mid();
    lat = 1;
    for (int i = 0; i < 10; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
